// File: rtl/uart_alu_defs.sv
// Shared definitions for the UART/ALU test design: FSM state encodings,
// ALU opcode constants and default operand/opcode widths.
package uart_alu_defs;

  localparam int unsigned DEF_N_BITS = 8;
  localparam int unsigned DEF_N_OP   = 6;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_WAIT = 3'd4
  } ctrl_state_t;

  // ALU opcodes (function field values)
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects operand A, operand B and opcode bytes from the UART
// receiver, presents them as registered ALU inputs, captures the ALU result
// and launches a single transmit, then waits for transmit completion.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_rx_data/i_rx_done received byte and its one-cycle valid pulse
//   i_tx_done           transmitter frame-complete pulse
//   i_alu_result        combinational ALU result
//   o_alu_a/o_alu_b/o_alu_op  registered ALU inputs
//   o_tx_data/o_tx_start      registered transmit byte and launch pulse
//   o_busy              high while executing / waiting for transmit
//   o_timeout           inter-byte timeout pulse
//
// Optional feature: define UART_ALU_CTRL_TIMEOUT_EN to build the inter-byte
// timeout counter; otherwise o_timeout is tied low.
module uart_alu_ctrl
  import uart_alu_defs::*;
#(
  parameter int unsigned N_BITS         = DEF_N_BITS,
  parameter int unsigned N_OP           = DEF_N_OP,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_tx_done,
  input  logic [N_BITS-1:0] i_alu_result,
  output logic [N_BITS-1:0] o_alu_a,
  output logic [N_BITS-1:0] o_alu_b,
  output logic [N_OP-1:0]   o_alu_op,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic              o_timeout
);

  ctrl_state_t state;
  logic        timeout_hit;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             collecting;

  assign collecting  = (state == S_B) || (state == S_OP);
  // Expiry cycle is the TIMEOUT_CYCLES-th idle cycle; a byte in it wins
  assign timeout_hit = collecting && !i_rx_done &&
                       (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter, only live while waiting for B or the opcode
  always_ff @(posedge i_clk) begin
    if (i_reset || !collecting || i_rx_done || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // One-cycle timeout pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_hit;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign o_timeout          = 1'b0;
`endif

  // Sequencer with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        S_A: begin
          if (i_rx_done) begin
            o_alu_a <= i_rx_data;
            state   <= S_B;
          end
        end
        S_B: begin
          if (i_rx_done) begin
            o_alu_b <= i_rx_data;
            state   <= S_OP;
          end else if (timeout_hit) begin
            state <= S_A;
          end
        end
        S_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[N_OP-1:0];
            o_busy   <= 1'b1;
            state    <= S_EXEC;
          end else if (timeout_hit) begin
            state <= S_A;
          end
        end
        S_EXEC: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= S_A;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: table of byte triples with expected
// results, a scoreboard queue of expected tx bytes, plus corner sequences.
module tb_uart_alu_ctrl;
  import uart_alu_defs::*;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam int unsigned TO_CYC = 100;
`else
  localparam int unsigned TO_CYC = 50_000_000;
`endif

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_done = 1'b0;
  logic       i_tx_done = 1'b0;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_exp_start = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  uart_alu_ctrl #(.N_BITS(8), .N_OP(6), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data),
    .i_rx_done(i_rx_done), .i_tx_done(i_tx_done), .i_alu_result(i_alu_result),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  // Behavioural ALU
  always_comb begin
    i_alu_result = 8'h00;
    case (o_alu_op)
      OP_ADD: i_alu_result = o_alu_a + o_alu_b;
      OP_SUB: i_alu_result = o_alu_a - o_alu_b;
      OP_AND: i_alu_result = o_alu_a & o_alu_b;
      OP_OR:  i_alu_result = o_alu_a | o_alu_b;
      OP_XOR: i_alu_result = o_alu_a ^ o_alu_b;
      OP_SRA: i_alu_result = 8'($signed(o_alu_a) >>> o_alu_b);
      OP_SRL: i_alu_result = o_alu_a >> o_alu_b;
      OP_NOR: i_alu_result = ~(o_alu_a | o_alu_b);
      default: i_alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every launch pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!i_reset && o_tx_start) begin
      n_start++;
      if (sb_q.size() == 0) begin
        chk("unexpected_tx_start", 32'(o_tx_start), 32'd0);
      end else begin
        chk("tx_data", 32'(o_tx_data), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, 32'(o_alu_a), 32'd0);
    chk({tag, "_b"}, 32'(o_alu_b), 32'd0);
    chk({tag, "_op"}, 32'(o_alu_op), 32'd0);
    chk({tag, "_txd"}, 32'(o_tx_data), 32'd0);
    chk({tag, "_start"}, 32'(o_tx_start), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
    int         tx_delay;
    bit         inject_wait;
    bit         txdone_in_b;
  } vec_t;

  task automatic run_vec(input vec_t v);
    send_byte(v.a);
    chk("alu_a", 32'(o_alu_a), 32'(v.a));
    if (v.txdone_in_b) begin
      i_tx_done = 1'b1;
      @(negedge clk);
      i_tx_done = 1'b0;
      chk("txdone_in_b_busy", 32'(o_busy), 32'd0);
      chk("txdone_in_b_a", 32'(o_alu_a), 32'(v.a));
    end
    send_byte(v.b);
    chk("alu_b", 32'(o_alu_b), 32'(v.b));
    sb_q.push_back(v.exp_res);
    n_exp_start++;
    send_byte(v.opb);
    // now in S_EXEC
    chk("alu_op", 32'(o_alu_op), 32'(v.exp_op));
    chk("exec_busy", 32'(o_busy), 32'd1);
    chk("exec_start", 32'(o_tx_start), 32'd0);
    @(negedge clk);
    chk("launch_start", 32'(o_tx_start), 32'd1);
    chk("launch_busy", 32'(o_busy), 32'd1);
    if (v.inject_wait) begin
      send_byte(8'h11);
      chk("inject_start", 32'(o_tx_start), 32'd0);
      chk("inject_busy", 32'(o_busy), 32'd1);
    end
    for (int i = 0; i < v.tx_delay; i++) begin
      @(negedge clk);
      chk("wait_start", 32'(o_tx_start), 32'd0);
      chk("wait_busy", 32'(o_busy), 32'd1);
    end
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk("done_busy", 32'(o_busy), 32'd0);
    chk("done_start", 32'(o_tx_start), 32'd0);
    chk("done_a_kept", 32'(o_alu_a), 32'(v.a));
    chk("done_b_kept", 32'(o_alu_b), 32'(v.b));
  endtask

  vec_t vecs[10];

  initial begin
    //            a      b      opb    op     res   dly inj txb
    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 2, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 8'h3C, 8'h26, 6'h26, 8'h00, 3, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF, 1, 1'b0, 1'b0};
    vecs[3] = '{8'h09, 8'h0C, 8'h22, 6'h22, 8'hFD, 0, 1'b0, 1'b1};
    vecs[4] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30, 1, 1'b0, 1'b0};
    vecs[5] = '{8'hAA, 8'hFF, 8'h26, 6'h26, 8'h55, 0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h02, 8'h03, 6'h03, 8'hE0, 0, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'h02, 8'h02, 6'h02, 8'h20, 0, 1'b0, 1'b0};
    vecs[8] = '{8'h0F, 8'h30, 8'h27, 6'h27, 8'hC0, 0, 1'b0, 1'b0};
    vecs[9] = '{8'h10, 8'h20, 8'hE0, 6'h20, 8'h30, 1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    i_reset = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // Table: rows 5..8 are back-to-back with tx_done on the launch cycle
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset after A and B discards the partial triple
    send_byte(8'h77);
    send_byte(8'h66);
    chk("partial_b", 32'(o_alu_b), 32'h66);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check_zero("mid_reset");
    run_vec('{8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 1, 1'b0, 1'b0});

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    // A byte then TO_CYC idle cycles -> timeout pulse, back to S_A
    send_byte(8'h21);
    repeat (TO_CYC - 1) @(negedge clk);
    chk("to_not_yet", 32'(o_timeout), 32'd0);
    @(negedge clk);
    chk("to_pulse", 32'(o_timeout), 32'd1);
    @(negedge clk);
    chk("to_pulse_end", 32'(o_timeout), 32'd0);
    chk("to_b_kept", 32'(o_alu_b), 32'h02);
    send_byte(8'h44);
    chk("to_new_a", 32'(o_alu_a), 32'h44);
    // Byte in the expiry cycle wins
    repeat (TO_CYC - 1) @(negedge clk);
    send_byte(8'h55);
    chk("to_byte_wins_b", 32'(o_alu_b), 32'h55);
    chk("to_byte_wins_flag", 32'(o_timeout), 32'd0);
    sb_q.push_back(8'h99);
    n_exp_start++;
    send_byte(8'h20);
    chk("to_op", 32'(o_alu_op), 32'h20);
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk("to_done_busy", 32'(o_busy), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("start_pulses", 32'(n_start), 32'(n_exp_start));
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
